// File: rtl/datapath_bus.sv
// datapath_bus: single-bus register datapath with one-hot source select, RAM, PC and bus-conflict tracking.
module datapath_bus (
   input  logic        clk,
   input  logic        reset,
   input  logic        idr_0,
   input  logic        edr_0,
   input  logic        idr_1,
   input  logic        edr_1,
   input  logic        idr_bp,
   input  logic        edr_bp,
   input  logic        idr_sp,
   input  logic        edr_sp,
   input  logic        icode,
   input  logic        eir,
   input  logic        imar,
   input  logic        emar,
   input  logic        iaddr,
   input  logic        iram,
   input  logic        eram,
   input  logic        ialu,
   input  logic        ealu,
   input  logic        ipc,
   input  logic        epc,
   input  logic [15:0] code_in,
   input  logic [15:0] alu_y,
   output logic [15:0] cmd,
   output logic [15:0] bus,
   output logic [7:0]  pc,
   output logic [15:0] alu_a,
   output logic [15:0] r0,
   output logic [15:0] r1,
   output logic [15:0] bp,
   output logic [15:0] sp,
   output logic        bus_err,
   output logic [7:0]  err_cnt
);
   logic [15:0] r0_q, r0_d, r1_q, r1_d, bp_q, bp_d, sp_q, sp_d;
   logic [15:0] ir_q, ir_d, mar_q, mar_d, alu_a_q, alu_a_d;
   logic [7:0]  pc_q, pc_d, addr_q, addr_d, err_cnt_q, err_cnt_d;
   logic        bus_err_q, bus_err_d;
   logic [15:0] mem [256];
   logic [15:0] ram_rd;
   logic [8:0]  src;
   logic        conflict, wr;
   assign ram_rd = mem[addr_q];
   always_comb begin
      src = {edr_0, edr_1, edr_bp, edr_sp, eir, emar, eram, ealu, epc};
      conflict = $countones(src) > 1;
      wr = !conflict;
      // with at most one source enabled the AND-OR mux is exact; no source yields zero
      bus = conflict ? 16'h0000 :
            ({16{edr_0}} & r0_q) | ({16{edr_1}} & r1_q) | ({16{edr_bp}} & bp_q) |
            ({16{edr_sp}} & sp_q) | ({16{eir}} & ir_q) | ({16{emar}} & mar_q) |
            ({16{eram}} & ram_rd) | ({16{ealu}} & alu_y) | ({16{epc}} & {8'h00, pc_q});
      r0_d = (wr && idr_0) ? bus : r0_q;
      r1_d = (wr && idr_1) ? bus : r1_q;
      bp_d = (wr && idr_bp) ? bus : bp_q;
      sp_d = (wr && idr_sp) ? bus : sp_q;
      mar_d = (wr && imar) ? bus : mar_q;
      alu_a_d = (wr && ialu) ? bus : alu_a_q;
      addr_d = (wr && iaddr) ? bus[7:0] : addr_q;
      ir_d = icode ? code_in : ir_q;
      pc_d = pc_q + {7'd0, ipc};
      bus_err_d = bus_err_q | conflict;
      err_cnt_d = (conflict && err_cnt_q != 8'hFF) ? err_cnt_q + 8'h01 : err_cnt_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r0_q <= 16'h0000;
         r1_q <= 16'h0000;
         bp_q <= 16'h0000;
         sp_q <= 16'h0000;
         ir_q <= 16'h0000;
         mar_q <= 16'h0000;
         alu_a_q <= 16'h0000;
         pc_q <= 8'h00;
         addr_q <= 8'h00;
         bus_err_q <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         r0_q <= r0_d;
         r1_q <= r1_d;
         bp_q <= bp_d;
         sp_q <= sp_d;
         ir_q <= ir_d;
         mar_q <= mar_d;
         alu_a_q <= alu_a_d;
         pc_q <= pc_d;
         addr_q <= addr_d;
         bus_err_q <= bus_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end
   // RAM keeps its contents through reset but must not be written while reset is high
   always_ff @(posedge clk) begin
      if (iram && wr && !reset) mem[addr_q] <= bus;
   end
   assign cmd = ir_q;
   assign pc = pc_q;
   assign alu_a = alu_a_q;
   assign r0 = r0_q;
   assign r1 = r1_q;
   assign bp = bp_q;
   assign sp = sp_q;
   assign bus_err = bus_err_q;
   assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_datapath_bus.sv
// tb_datapath_bus: directed and randomized checks of datapath_bus against a behavioural bus model.
module tb_datapath_bus;
   localparam int I_R0 = 0, E_R0 = 1, I_R1 = 2, E_R1 = 3, I_BP = 4, E_BP = 5, I_SP = 6, E_SP = 7;
   localparam int ICODE = 8, EIR = 9, IMAR = 10, EMAR = 11, IADDR = 12, IRAM = 13, ERAM = 14;
   localparam int IALU = 15, EALU = 16, IPC = 17, EPC = 18;
   logic clk = 1'b0, reset = 1'b1;
   logic [18:0] ctl = '0;
   logic [15:0] code_in = '0, alu_y = '0;
   logic [15:0] cmd, bus, alu_a, r0, r1, bp, sp;
   logic [7:0] pc, err_cnt;
   logic bus_err;
   int checks = 0, errors = 0;
   logic [15:0] m_r [4];
   logic [15:0] m_ir, m_mar, m_alu;
   logic [7:0] m_pc, m_addr, m_cnt;
   logic m_err;
   logic [15:0] m_ram [256];
   bit m_vld [256];

   datapath_bus dut (
      .clk(clk), .reset(reset),
      .idr_0(ctl[I_R0]), .edr_0(ctl[E_R0]), .idr_1(ctl[I_R1]), .edr_1(ctl[E_R1]),
      .idr_bp(ctl[I_BP]), .edr_bp(ctl[E_BP]), .idr_sp(ctl[I_SP]), .edr_sp(ctl[E_SP]),
      .icode(ctl[ICODE]), .eir(ctl[EIR]), .imar(ctl[IMAR]), .emar(ctl[EMAR]),
      .iaddr(ctl[IADDR]), .iram(ctl[IRAM]), .eram(ctl[ERAM]), .ialu(ctl[IALU]),
      .ealu(ctl[EALU]), .ipc(ctl[IPC]), .epc(ctl[EPC]),
      .code_in(code_in), .alu_y(alu_y), .cmd(cmd), .bus(bus), .pc(pc), .alu_a(alu_a),
      .r0(r0), .r1(r1), .bp(bp), .sp(sp), .bus_err(bus_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic int n_src();
      return int'(ctl[E_R0]) + int'(ctl[E_R1]) + int'(ctl[E_BP]) + int'(ctl[E_SP]) + int'(ctl[EIR]) +
             int'(ctl[EMAR]) + int'(ctl[ERAM]) + int'(ctl[EALU]) + int'(ctl[EPC]);
   endfunction

   function automatic logic [15:0] m_bus();
      if (n_src() != 1) return 16'h0000;
      if (ctl[E_R0]) return m_r[0];
      if (ctl[E_R1]) return m_r[1];
      if (ctl[E_BP]) return m_r[2];
      if (ctl[E_SP]) return m_r[3];
      if (ctl[EIR]) return m_ir;
      if (ctl[EMAR]) return m_mar;
      if (ctl[ERAM]) return m_ram[m_addr];
      if (ctl[EALU]) return alu_y;
      return {8'h00, m_pc};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
      m_ir = 0; m_mar = 0; m_alu = 0; m_pc = 0; m_addr = 0; m_cnt = 0; m_err = 0;
   endtask

   task automatic m_clock();
      logic [15:0] b;
      b = m_bus();
      if (n_src() <= 1) begin
         if (ctl[I_R0]) m_r[0] = b;
         if (ctl[I_R1]) m_r[1] = b;
         if (ctl[I_BP]) m_r[2] = b;
         if (ctl[I_SP]) m_r[3] = b;
         if (ctl[IMAR]) m_mar = b;
         if (ctl[IALU]) m_alu = b;
         if (ctl[IRAM]) begin m_ram[m_addr] = b; m_vld[m_addr] = 1'b1; end
         if (ctl[IADDR]) m_addr = b[7:0];
      end else begin
         m_err = 1'b1;
         m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'h01;
      end
      if (ctl[ICODE]) m_ir = code_in;
      if (ctl[IPC]) m_pc = m_pc + 8'h01;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("bus", bus, m_bus());
      chk("cmd", cmd, m_ir);
      chk("pc", {8'h00, pc}, {8'h00, m_pc});
      chk("alu_a", alu_a, m_alu);
      chk("r0", r0, m_r[0]);
      chk("r1", r1, m_r[1]);
      chk("bp", bp, m_r[2]);
      chk("sp", sp, m_r[3]);
      chk("bus_err", {15'd0, bus_err}, {15'd0, m_err});
      chk("err_cnt", {8'h00, err_cnt}, {8'h00, m_cnt});
   endtask

   task automatic step();
      #1 check_all();
      @(posedge clk);
      m_clock();
      #1;
   endtask

   task automatic go(input logic [18:0] c);
      ctl = c;
      step();
   endtask

   function automatic logic [18:0] b(input int i);
      return 19'd1 << i;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
      m_reset();
      #1 check_all();
      chk("reset_r0", r0, 16'h0000);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) go(b(IPC));
      chk("pc_wrap", {8'h00, pc}, 16'h0000);
      for (int i = 0; i < 5; i++) go(b(IPC));
      go(b(EPC) | b(IPC) | b(I_R0));
      chk("epc_r0", r0, 16'h0005);
      chk("epc_pc", {8'h00, pc}, 16'h0006);
      code_in = 16'h1234;
      go(b(ICODE));
      chk("icode_cmd", cmd, 16'h1234);
      go(b(EIR) | b(I_R0));
      chk("eir_r0", r0, 16'h1234);
      chk("eir_err", {15'd0, bus_err}, 16'h0000);
      alu_y = 16'hABCD;
      go(b(EALU) | b(I_R1));
      go(b(E_R1) | b(IADDR));
      go(b(E_R1) | b(IRAM));
      ctl = b(ERAM) | b(I_SP);
      #1 chk("eram_bus", bus, 16'hABCD);
      step();
      chk("ram_sp", sp, 16'hABCD);
      chk("model_ram_cd", m_ram[8'hCD], 16'hABCD);
      alu_y = 16'h00FF;
      go(b(EALU) | b(I_R0));
      go(b(E_R0) | b(I_R0) | b(IALU));
      chk("self_r0", r0, 16'h00FF);
      chk("self_alu", alu_a, 16'h00FF);
      go(b(I_R1));
      chk("nosrc_r1", r1, 16'h0000);
      alu_y = 16'h7777;
      go(b(EALU) | b(I_BP));
      ctl = b(E_R0) | b(E_R1) | b(I_BP);
      #1 chk("conf_bus", bus, 16'h0000);
      step();
      chk("conf_bp", bp, 16'h7777);
      chk("conf_err", {15'd0, bus_err}, 16'h0001);
      chk("conf_cnt", {8'h00, err_cnt}, 16'h0001);
      for (int i = 0; i < 300; i++) step();
      chk("conf_sat", {8'h00, err_cnt}, 16'h00FF);
      for (int k = 0; k < 600; k++) begin
         logic [18:0] c;
         c = '0;
         for (int i = 0; i < 19; i++) begin
            bit is_src;
            is_src = (i == E_R0 || i == E_R1 || i == E_BP || i == E_SP || i == EIR ||
                      i == EMAR || i == ERAM || i == EALU || i == EPC);
            c[i] = is_src ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
         end
         if (!m_vld[m_addr]) c[ERAM] = 1'b0;
         code_in = 16'($urandom);
         alu_y = 16'($urandom);
         go(c);
      end
      alu_y = 16'h0000;
      go(b(EALU) | b(IADDR));
      alu_y = 16'h5A5A;
      go(b(EALU) | b(IRAM));
      alu_y = 16'h1111;
      go(b(EALU) | b(I_R0));
      ctl = b(E_R0) | b(IRAM);
      #2 reset = 1'b1;
      #1 m_reset();
      chk("rst_r0", r0, 16'h0000);
      chk("rst_r1", r1, 16'h0000);
      chk("rst_bp", bp, 16'h0000);
      chk("rst_sp", sp, 16'h0000);
      chk("rst_cmd", cmd, 16'h0000);
      chk("rst_alu", alu_a, 16'h0000);
      chk("rst_pc", {8'h00, pc}, 16'h0000);
      chk("rst_cnt", {8'h00, err_cnt}, 16'h0000);
      chk("rst_err", {15'd0, bus_err}, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b0;
      ctl = b(ERAM);
      #1 chk("rst_ram0", bus, 16'h5A5A);
      step();
      alu_y = 16'h00CD;
      go(b(EALU) | b(IADDR));
      go(b(ERAM) | b(I_R1));
      go('0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/datapath_bus.md
DATAPATH_BUS -- requirements
Module: datapath_bus

Interface
REQ-001 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on its rising edge
  reset  in  1  asynchronous, active-high reset
  idr_0/edr_0, idr_1/edr_1, idr_bp/edr_bp, idr_sp/edr_sp  in  1 each  latch-from-bus / drive-to-bus for r0, r1, bp, sp
  icode  in  1  latch code_in into IR
  eir  in  1  drive IR onto bus
  imar  in  1  latch bus into MAR
  emar  in  1  drive MAR onto bus
  iaddr  in  1  latch bus[7:0] into RAM address register ADDR
  iram  in  1  write bus into RAM[ADDR]
  eram  in  1  drive RAM[ADDR] onto bus
  ialu  in  1  latch bus into ALU operand register
  ealu  in  1  drive alu_y onto bus
  ipc  in  1  increment PC
  epc  in  1  drive PC, zero-extended, onto bus
  code_in  in  16  instruction word source
  alu_y  in  16  ALU result
  cmd  out  16  current IR, feeds the controller
  bus  out  16  current internal bus value
  pc  out  8  program counter
  alu_a  out  16  ALU operand register
  r0, r1, bp, sp  out  16 each  register contents
  bus_err  out  1  sticky bus-conflict flag
  err_cnt  out  8  saturating bus-conflict count
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.

Function
REQ-003 Sources SHALL be edr_0, edr_1, edr_bp, edr_sp, eir, emar, eram, ealu, epc; their count per cycle is N.
REQ-004 N=1: bus SHALL equal the selected source, combinationally, in the same cycle.
REQ-005 N=0: bus SHALL be 16'h0000; sinks asserted in that cycle SHALL latch 16'h0000.
REQ-006 N>=2 (conflict): bus SHALL be 16'h0000, all sink writes (idr_*, imar, iaddr, iram, ialu) SHALL be suppressed that cycle, bus_err SHALL set at the edge, err_cnt SHALL increment, saturating at 8'hFF.
REQ-007 icode and ipc are not bus sinks; they SHALL act even in a conflict cycle.
REQ-008 Each sink asserted at a rising edge SHALL capture bus; the new value SHALL be visible from the next cycle, so one-cycle source-to-sink latency.
REQ-009 A register both driving and latching in one cycle SHALL retain its value.
REQ-010 Several sinks in one cycle SHALL all capture the same bus value.
REQ-011 iaddr SHALL capture bus[7:0]; upper byte ignored.
REQ-012 RAM SHALL be 256x16, combinational read at ADDR, synchronous write on iram; not reset.
REQ-013 eram with iram in the same cycle SHALL leave RAM[ADDR] unchanged (reads old data).
REQ-014 iaddr with eram or iram in the same cycle SHALL use the old ADDR.
REQ-015 ipc SHALL add 1 to PC per asserted cycle, wrapping 8'hFF to 8'h00; epc with ipc in one cycle SHALL drive the pre-increment PC.
REQ-016 icode SHALL load code_in into IR; cmd SHALL equal IR.
REQ-017 bus_err SHALL clear only on reset.

Reset
REQ-018 reset high SHALL immediately, without clk, set r0, r1, bp, sp, IR, MAR, alu_a to 16'h0000, PC and ADDR to 8'h00, bus_err to 0, err_cnt to 8'h00.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer; no sink updates while reset is high.
REQ-020 RAM contents SHALL be preserved through reset.

Verification
REQ-021 code_in=16'h1234, icode; next cycle eir+idr_0 -> cmd=16'h1234 one cycle after icode; r0=16'h1234 one cycle later; bus_err=0.
REQ-022 r1=16'hABCD; edr_1+iaddr (bus[7:0]=8'hCD), then edr_1+iram, then eram+idr_sp -> RAM[8'hCD]=16'hABCD, sp=16'hABCD.
REQ-023 edr_0+edr_1+idr_bp in one cycle -> bus=16'h0000, bp unchanged, bus_err=1, err_cnt=1; repeat 300 conflict cycles -> err_cnt=8'hFF.
REQ-024 ipc held 256 cycles from PC=8'h00 -> PC=8'h00; epc+ipc at PC=8'h05 with idr_0 -> r0=16'h0005, PC=8'h06.
REQ-025 r0=16'h00FF, edr_0+idr_0+ialu -> r0 stays 16'h00FF, alu_a=16'h00FF; no sources + idr_1 -> r1=16'h0000.
REQ-026 reset pulsed between clk edges during edr_0+iram -> all registers, PC, ADDR, err_cnt zero immediately; RAM[ADDR] unchanged; RAM contents written earlier still readable after reset.
